pwm_fade_ctrl: RTL and testbench

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_fade_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
// PWM fade controller: SPI-written enable registers plus a duty-cycle sequencer that ramps toward TARGET.
// Optional build macro FADE_LOOP_EN adds ping-pong looping between the start duty and TARGET.
module pwm_fade_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_we,
    input  logic [2:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_DONE} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   en_out_lo_q, en_out_lo_d, en_out_hi_q, en_out_hi_d;
    logic [DW-1:0]   en_pwm_lo_q, en_pwm_lo_d, en_pwm_hi_q, en_pwm_hi_d;
    logic [DW-1:0]   target_q, target_d, step_q, step_d, interval_q, interval_d;
    logic [DW-1:0]   tick_q, tick_d, duty_q, duty_d;
    logic            busy_q, busy_d, done_q, done_d;

    logic            ctrl_wr_c, start_c, abort_c, step_c, reached_c, loop_hit_c;
    logic [DW-1:0]   step_eff_c, step_val_c;
    logic [DW:0]     sum_c, diff_c;

`ifdef FADE_LOOP_EN
    logic [DW-1:0]   origin_q, origin_d;
    logic            loop_q, loop_d;
    assign loop_hit_c = reached_c && loop_q;
`else
    assign loop_hit_c = 1'b0;
`endif

    assign ctrl_wr_c = cfg_we && (cfg_addr == 3'd7);
    assign start_c   = ctrl_wr_c && cfg_wdata[0] && !cfg_wdata[1];
    assign abort_c   = ctrl_wr_c && cfg_wdata[1];
    assign step_c    = (state_q == ST_RAMP) && (tick_q == '0);

    // One duty step toward TARGET in 9-bit arithmetic, clamped so it never overshoots or wraps
    always_comb begin
        step_eff_c = (step_q == '0) ? DW'(1) : step_q;
        sum_c      = {1'b0, duty_q} + {1'b0, step_eff_c};
        diff_c     = {1'b0, duty_q} - {1'b0, step_eff_c};
        step_val_c = target_q;
        if (duty_q < target_q) begin
            if (sum_c < {1'b0, target_q}) step_val_c = sum_c[DW-1:0];
        end else if (duty_q > target_q) begin
            if (!diff_c[DW] && (diff_c[DW-1:0] > target_q)) step_val_c = diff_c[DW-1:0];
        end
    end

    assign reached_c = step_c && (step_val_c == target_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state; abort overrides everything, including a simultaneous start
    always_comb begin
        state_d = state_q;
        if (abort_c) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_c) state_d = (duty_q == target_q) ? ST_DONE : ST_RAMP;
                ST_RAMP: if (reached_c && !loop_hit_c) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        en_out_lo_d = en_out_lo_q;
        en_out_hi_d = en_out_hi_q;
        en_pwm_lo_d = en_pwm_lo_q;
        en_pwm_hi_d = en_pwm_hi_q;
        target_d    = target_q;
        step_d      = step_q;
        interval_d  = interval_q;
        tick_d      = tick_q;
        duty_d      = duty_q;
        busy_d      = (state_d == ST_RAMP);
        done_d      = (state_d == ST_DONE) || (loop_hit_c && !abort_c);
`ifdef FADE_LOOP_EN
        origin_d    = origin_q;
        loop_d      = loop_q;
        if (abort_c) loop_d = 1'b0;
        else if ((state_q == ST_IDLE) && start_c) begin
            loop_d   = cfg_wdata[2];
            origin_d = duty_q;
        end
        if (loop_hit_c && !abort_c) begin
            target_d = origin_q;
            origin_d = target_q;
        end
`endif
        if ((state_q == ST_IDLE) && (state_d == ST_RAMP)) tick_d = interval_q;
        else if ((state_q == ST_RAMP) && (state_d == ST_RAMP))
            tick_d = (tick_q == '0) ? interval_q : tick_q - DW'(1);
        if (step_c && !abort_c) duty_d = step_val_c;
        // Register writes land last so a TARGET write beats a same-cycle loop swap
        if (cfg_we) begin
            case (cfg_addr)
                3'd0:    en_out_lo_d = cfg_wdata;
                3'd1:    en_out_hi_d = cfg_wdata;
                3'd2:    en_pwm_lo_d = cfg_wdata;
                3'd3:    en_pwm_hi_d = cfg_wdata;
                3'd4:    target_d    = cfg_wdata;
                3'd5:    step_d      = cfg_wdata;
                3'd6:    interval_d  = cfg_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_out_lo_q <= '0;
            en_out_hi_q <= '0;
            en_pwm_lo_q <= '0;
            en_pwm_hi_q <= '0;
            target_q    <= '0;
            step_q      <= '0;
            interval_q  <= '0;
            tick_q      <= '0;
            duty_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef FADE_LOOP_EN
            origin_q    <= '0;
            loop_q      <= 1'b0;
`endif
        end else begin
            en_out_lo_q <= en_out_lo_d;
            en_out_hi_q <= en_out_hi_d;
            en_pwm_lo_q <= en_pwm_lo_d;
            en_pwm_hi_q <= en_pwm_hi_d;
            target_q    <= target_d;
            step_q      <= step_d;
            interval_q  <= interval_d;
            tick_q      <= tick_d;
            duty_q      <= duty_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef FADE_LOOP_EN
            origin_q    <= origin_d;
            loop_q      <= loop_d;
`endif
        end
    end

    assign en_reg_out_7_0  = en_out_lo_q;
    assign en_reg_out_15_8 = en_out_hi_q;
    assign en_reg_pwm_7_0  = en_pwm_lo_q;
    assign en_reg_pwm_15_8 = en_pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Randomized bench for pwm_fade_ctrl against a trajectory-level fade model.
module tb_pwm_fade_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [7:0] cfg_wdata = '0;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       busy, done;

    int checks = 0;
    int failures = 0;
    logic [7:0] m_en [4];
    int m_duty;

    pwm_fade_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_en(input string tag);
        check({tag, "_out_lo"}, 16'(en_reg_out_7_0),  16'(m_en[0]));
        check({tag, "_out_hi"}, 16'(en_reg_out_15_8), 16'(m_en[1]));
        check({tag, "_pwm_lo"}, 16'(en_reg_pwm_7_0),  16'(m_en[2]));
        check({tag, "_pwm_hi"}, 16'(en_reg_pwm_15_8), 16'(m_en[3]));
    endtask

    task automatic check_status(input string tag, input int d, input logic b, input logic dn);
        check({tag, "_duty"}, 16'(pwm_duty_cycle), 16'(d));
        check({tag, "_busy"}, 16'(busy), 16'(b));
        check({tag, "_done"}, 16'(done), 16'(dn));
    endtask

    // Called #1 after a clock edge; the write lands on the next edge
    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (a < 3'd4) m_en[a] = d;
    endtask

    // Whole-fade model: list of duty values, one step every iv+1 clocks
    task automatic run_fade(input int tgt, input int stp, input int iv);
        int traj[$];
        int d, s, n, per, total, k;
        logic [7:0] r;
        wr(3'd4, 8'(tgt)); wr(3'd5, 8'(stp)); wr(3'd6, 8'(iv));
        s = (stp == 0) ? 1 : stp;
        d = m_duty;
        traj.push_back(d);
        while (d != tgt) begin
            if (d < tgt) d = (d + s > tgt) ? tgt : d + s;
            else         d = (d - s < tgt) ? tgt : d - s;
            traj.push_back(d);
        end
        n = traj.size() - 1;
        per = iv + 1;
        total = n * per;
        r = 8'($urandom);
        wr(3'd7, 8'h01);
        for (int j = 0; j <= total + 1; j++) begin
            k = j / per;
            if (k > n) k = n;
            check_status("fade", traj[k], j < total, j == total);
            if (j == 2) check_en("wr_in_fade");
            if (j == 0) begin cfg_we = 1'b1; cfg_addr = 3'd7; cfg_wdata = 8'h01; end
            else if (j == 1) begin cfg_we = 1'b1; cfg_addr = 3'd3; cfg_wdata = r; end
            @(posedge clk); #1;
            cfg_we = 1'b0;
            if (j == 1) m_en[3] = r;
        end
        m_duty = tgt;
    endtask

    initial begin
        int tgt;
        for (int i = 0; i < 4; i++) m_en[i] = '0;
        m_duty = 0;
        #12;
        check_en("reset");
        check_status("reset", 0, 1'b0, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        wr(3'd0, 8'hA5);
        check_en("wr0");
        wr(3'd2, 8'h3C);
        check_en("wr2");
        wr(3'd1, 8'h5A);
        wr(3'd3, 8'hC3);
        check_en("wr13");

        run_fade(8'h10, 4, 2);
        run_fade(8'h20, 8'h20, 0);
        run_fade(8'h05, 8'h10, 1);
        run_fade(8'h05, 3, 1);

        wr(3'd7, 8'h03);
        check_status("start_abort", m_duty, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_status("start_abort2", m_duty, 1'b0, 1'b0);
        wr(3'd4, 8'h40); wr(3'd5, 8'd3); wr(3'd6, 8'd3);
        wr(3'd7, 8'h01);
        repeat (4) @(posedge clk);
        #1;
        check_status("pre_abort", 8'h08, 1'b1, 1'b0);
        wr(3'd7, 8'h02);
        for (int j = 0; j < 6; j++) begin
            check_status("abort_hold", 8'h08, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        m_duty = 8'h08;

        for (int f = 0; f < 8; f++) begin
            tgt = int'($urandom_range(0, 255));
            run_fade(tgt, (f == 3) ? 0 : int'($urandom_range(1, 60)), int'($urandom_range(0, 3)));
        end

        wr(3'd4, 8'(m_duty ^ 8'h80)); wr(3'd5, 8'd1); wr(3'd6, 8'd0);
        wr(3'd7, 8'h01);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) m_en[i] = '0;
        m_duty = 0;
        check_en("rst_mid");
        check_status("rst_mid", 0, 1'b0, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        wr(3'd7, 8'h01);
        check_status("post_rst_start", 0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check_status("post_rst_idle", 0, 1'b0, 1'b0);

`ifdef FADE_LOOP_EN
        wr(3'd4, 8'h08); wr(3'd5, 8'h08); wr(3'd6, 8'h00);
        wr(3'd7, 8'h05);
        for (int j = 0; j <= 6; j++) begin
            if (j == 0) check_status("loop", 0, 1'b1, 1'b0);
            else        check_status("loop", (j % 2 == 1) ? 8 : 0, 1'b1, 1'b1);
            @(posedge clk); #1;
        end
        wr(3'd7, 8'h02);
        check_status("loop_abort", 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_status("loop_abort2", 0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
